// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared constants and types for the UART Avalon-MM sequencer.
//   - UART register word addresses (ADDR_RXDATA .. ADDR_DIVISOR)
//   - status register bit indices (ST_PE .. ST_E)
//   - controller state enum, grant enum, captured-status struct
//   - is_wr_state(): true for states that perform a two-cycle write access
package uart_ctrl_pkg;

  localparam logic [2:0] ADDR_RXDATA  = 3'd0;
  localparam logic [2:0] ADDR_TXDATA  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_CONTROL = 3'd3;
  localparam logic [2:0] ADDR_DIVISOR = 3'd4;

  localparam int ST_PE   = 0;
  localparam int ST_FE   = 1;
  localparam int ST_ROE  = 3;
  localparam int ST_TRDY = 6;
  localparam int ST_RRDY = 7;
  localparam int ST_E    = 8;

  // S_BOOT is the idle reset state so the bus is quiet while reset is held.
  typedef enum logic [3:0] {
    S_BOOT, S_INIT_DIV, S_INIT_CTL, S_IDLE, S_POLL, S_WAIT_ST,
    S_DECIDE, S_CLR_ST, S_WR_TX, S_RD_RX, S_WAIT_RX
  } ctrl_state_e;

  typedef enum logic {GRANT_RX = 1'b0, GRANT_TX = 1'b1} grant_e;

  // Only the status bits the controller acts on are kept.
  typedef struct packed {
    logic e;
    logic rrdy;
    logic trdy;
    logic roe;
    logic fe;
    logic pe;
  } uart_status_t;

  function automatic logic is_wr_state(ctrl_state_e s);
    return (s == S_INIT_DIV) || (s == S_INIT_CTL) || (s == S_CLR_ST) || (s == S_WR_TX);
  endfunction

endpackage

// File: rtl/uart_avalon_ctrl_if.sv
// uart_avalon_ctrl_if: Avalon-MM link between the controller (master) and
// the UART slave. 3-bit word address, 16-bit data, active-low strobes.
//   master: drives address/chipselect/begintransfer/read_n/write_n/writedata,
//           receives readdata and irq.
//   slave : the mirror image.
// Handshake: an access is the single cycle with chipselect=1; begintransfer
// equals chipselect, exactly one strobe is low, and read data is sampled at
// the clock edge that ends the following cycle.
interface uart_avalon_ctrl_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_begintransfer;
  logic        av_read_n;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_irq;

  modport master (
    output av_address, av_chipselect, av_begintransfer, av_read_n, av_write_n, av_writedata,
    input  av_readdata, av_irq
  );

  modport slave (
    input  av_address, av_chipselect, av_begintransfer, av_read_n, av_write_n, av_writedata,
    output av_readdata, av_irq
  );
endinterface

// File: rtl/uart_ctrl_arb.sv
// uart_ctrl_arb: RX/TX round-robin decision for the single UART port.
//   clk, rst_n           : clock, async active-low reset
//   rx_want, tx_want     : requests evaluated in DECIDE
//   upd_en, upd_side     : record which side was actually served
//   grant_rx, grant_tx   : one-hot (or none) combinational grant
//   last_grant           : side served most recently (resets to TX so the
//                          first contended grant goes to RX)
module uart_ctrl_arb
  import uart_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   rx_want,
  input  logic   tx_want,
  input  logic   upd_en,
  input  grant_e upd_side,
  output logic   grant_rx,
  output logic   grant_tx,
  output grant_e last_grant
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= GRANT_TX;
    else if (upd_en) last_grant <= upd_side;
  end

  always_comb begin
    grant_rx = 1'b0;
    grant_tx = 1'b0;
    if (rx_want && tx_want) begin
      if (last_grant == GRANT_TX) grant_rx = 1'b1;
      else                        grant_tx = 1'b1;
    end else begin
      grant_rx = rx_want;
      grant_tx = tx_want;
    end
  end

endmodule

// File: rtl/uart_avalon_ctrl.sv
// uart_avalon_ctrl: Avalon-MM master that initialises the UART (divisor,
// control), then polls status and moves bytes between the UART and a pair
// of valid/ready byte streams, clearing error flags when reported.
// Ports:
//   clk_clk, reset_reset_n     : clock, async active-low reset
//   tx_data/tx_valid/tx_ready  : TX byte stream in (1-entry holding reg)
//   rx_data/rx_valid/rx_ready  : RX byte stream out (1-entry output reg)
//   err_sticky, err_clr        : sticky PE/FE/ROE flag and its clear
//   av                         : Avalon-MM master port (uart_avalon_ctrl_if)
//   state_dbg                  : current controller state
// Build option: define UART_CTRL_IRQ_EN to leave IDLE only on av_irq,
// a pending TX byte, or a freshly drained RX register (POLL_GAP is then the
// minimum gap). Without it av_irq is ignored and polling is periodic.
module uart_avalon_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [15:0] INIT_DIVISOR = 16'd434,
  parameter logic [15:0] INIT_CONTROL = 16'h0000,
  parameter int unsigned POLL_GAP     = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        err_sticky,
  input  logic        err_clr,
  uart_avalon_ctrl_if.master av,
  output ctrl_state_e state_dbg
);

  localparam logic [15:0] GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

  ctrl_state_e  state_q, state_d;
  logic         wr_phase_q;   // 0: strobe cycle of a write, 1: recovery cycle
  logic         tx_full_q;
  logic [7:0]   tx_byte_q;
  uart_status_t st_q;
  logic [15:0]  poll_cnt_q;
  logic         gap_done, leave_idle, init_done;
  logic         grant_rx, grant_tx, upd_en;
  logic         wr_strobe, rd_strobe;
  grant_e       last_grant;

  assign state_dbg = state_q;
  assign init_done = !(state_q inside {S_BOOT, S_INIT_DIV, S_INIT_CTL});
  assign tx_ready  = init_done && !tx_full_q;
  assign gap_done  = (POLL_GAP == 0) || (poll_cnt_q >= GAP_LAST);

`ifdef UART_CTRL_IRQ_EN
  logic rx_freed_q;
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                    rx_freed_q <= 1'b0;
    else if (rx_valid && rx_ready)         rx_freed_q <= 1'b1;
    else if (state_q == S_IDLE && leave_idle) rx_freed_q <= 1'b0;
  end
  assign leave_idle = gap_done && (av.av_irq || tx_full_q || rx_freed_q);
`else
  logic unused_irq;
  assign unused_irq = av.av_irq;
  assign leave_idle = gap_done;
`endif

  logic unused_rd_bits;
  assign unused_rd_bits = ^{av.av_readdata[15:9], av.av_readdata[5:4], av.av_readdata[2]};

  uart_ctrl_arb u_arb (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .rx_want    (st_q.rrdy && !rx_valid),
    .tx_want    (st_q.trdy && tx_full_q),
    .upd_en     (upd_en),
    .upd_side   ((state_q == S_WAIT_RX) ? GRANT_RX : GRANT_TX),
    .grant_rx   (grant_rx),
    .grant_tx   (grant_tx),
    .last_grant (last_grant)
  );

  assign upd_en = (state_q == S_WAIT_RX) || (state_q == S_WR_TX && !wr_phase_q);

  // State register and write phase.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= S_BOOT;
      wr_phase_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_phase_q <= is_wr_state(state_q) && !wr_phase_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:     state_d = (INIT_DIVISOR != 16'd0) ? S_INIT_DIV : S_INIT_CTL;
      S_INIT_DIV: if (wr_phase_q) state_d = S_INIT_CTL;
      S_INIT_CTL: if (wr_phase_q) state_d = S_POLL;
      S_IDLE:     if (leave_idle) state_d = S_POLL;
      S_POLL:     state_d = S_WAIT_ST;
      S_WAIT_ST:  state_d = S_DECIDE;
      S_DECIDE: begin
        if (st_q.e)        state_d = S_CLR_ST;
        else if (grant_rx) state_d = S_RD_RX;
        else if (grant_tx) state_d = S_WR_TX;
`ifdef UART_CTRL_IRQ_EN
        else               state_d = S_IDLE;
`else
        else               state_d = (POLL_GAP == 0) ? S_POLL : S_IDLE;
`endif
      end
      S_CLR_ST:   if (wr_phase_q) state_d = S_POLL;
      S_WR_TX:    if (wr_phase_q) state_d = S_POLL;
      S_RD_RX:    state_d = S_WAIT_RX;
      S_WAIT_RX:  state_d = S_POLL;
      default:    state_d = S_BOOT;
    endcase
  end

  // Bus outputs: only the strobe cycle carries a non-idle value.
  assign wr_strobe = is_wr_state(state_q) && !wr_phase_q;
  assign rd_strobe = (state_q == S_POLL) || (state_q == S_RD_RX);

  always_comb begin
    av.av_chipselect    = wr_strobe || rd_strobe;
    av.av_begintransfer = wr_strobe || rd_strobe;
    av.av_write_n       = !wr_strobe;
    av.av_read_n        = !rd_strobe;
    av.av_address       = 3'd0;
    av.av_writedata     = 16'd0;
    case (state_q)
      S_INIT_DIV: if (!wr_phase_q) begin
        av.av_address   = ADDR_DIVISOR;
        av.av_writedata = INIT_DIVISOR;
      end
      S_INIT_CTL: if (!wr_phase_q) begin
        av.av_address   = ADDR_CONTROL;
        av.av_writedata = INIT_CONTROL;
      end
      S_CLR_ST:   if (!wr_phase_q) av.av_address = ADDR_STATUS;
      S_WR_TX: if (!wr_phase_q) begin
        av.av_address   = ADDR_TXDATA;
        av.av_writedata = {8'h00, tx_byte_q};
      end
      S_POLL:     av.av_address = ADDR_STATUS;
      S_RD_RX:    av.av_address = ADDR_RXDATA;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tx_full_q  <= 1'b0;
      tx_byte_q  <= 8'h00;
      rx_valid   <= 1'b0;
      rx_data    <= 8'h00;
      err_sticky <= 1'b0;
      st_q       <= '0;
      poll_cnt_q <= 16'd0;
    end else begin
      // tx_ready is low while full, so a load never coincides with the drain.
      if (state_q == S_WR_TX && !wr_phase_q) tx_full_q <= 1'b0;
      else if (tx_valid && tx_ready) begin
        tx_full_q <= 1'b1;
        tx_byte_q <= tx_data;
      end

      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      else if (state_q == S_WAIT_RX) begin
        rx_valid <= 1'b1;
        rx_data  <= av.av_readdata[7:0];
      end

      if (err_clr) err_sticky <= 1'b0;
      else if (state_q == S_CLR_ST && !wr_phase_q && (st_q.pe || st_q.fe || st_q.roe))
        err_sticky <= 1'b1;

      if (state_q == S_WAIT_ST) begin
        st_q.pe   <= av.av_readdata[ST_PE];
        st_q.fe   <= av.av_readdata[ST_FE];
        st_q.roe  <= av.av_readdata[ST_ROE];
        st_q.trdy <= av.av_readdata[ST_TRDY];
        st_q.rrdy <= av.av_readdata[ST_RRDY];
        st_q.e    <= av.av_readdata[ST_E];
      end

      // Counter saturates at the gap so IDLE can also wait on events.
      if (state_q != S_IDLE)   poll_cnt_q <= 16'd0;
      else if (!gap_done)      poll_cnt_q <= poll_cnt_q + 16'd1;
    end
  end

endmodule

// File: doc/uart_avalon_ctrl.md
Name: uart_avalon_ctrl

Overview:
- Avalon-MM master that sequences the system UART slave (3-bit word address, 16-bit data, active-low read/write strobes).
- On reset release it programs the baud divisor and control register.
- It then polls status, moving bytes between a valid/ready TX byte stream and the UART txdata register, and from the UART rxdata register to a valid/ready RX byte stream.
- Arbitrates RX vs TX access to the single slave port and clears UART error flags.

Parameters:
INIT_DIVISOR, 16'd434, value written to UART divisor register (addr 4) at init; 0 skips the divisor write.
INIT_CONTROL, 16'h0000, value written to UART control register (addr 3) at init.
POLL_GAP, 4, idle cycles between consecutive status polls when no transfer occurred (>=0).

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  controller can accept a TX byte
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid
rx_ready  in  1  consumer accepts rx_data
err_sticky  out  1  PE/FE/ROE seen since last clear
err_clr  in  1  clears err_sticky
av_address  out  3  UART register select
av_chipselect  out  1  slave select
av_begintransfer  out  1  first cycle of access
av_read_n  out  1  active-low read strobe
av_write_n  out  1  active-low write strobe
av_writedata  out  16  write data
av_readdata  in  16  read data
av_irq  in  1  UART interrupt (used only with the optional feature)

Behaviour:
- Clock and reset: single clock clk_clk; reset_reset_n asynchronous, active-low.
- Reset values:
  - av_chipselect=0, av_begintransfer=0, av_read_n=1, av_write_n=1, av_address=0, av_writedata=0.
  - tx_ready=0, rx_valid=0, rx_data=0, err_sticky=0.
  - Internal: tx_full=0, last_grant=TX, poll counter=0.
- Register map: 0 rxdata, 1 txdata, 2 status, 3 control, 4 divisor.
- Status bits: PE=0, FE=1, ROE=3, TRDY=6, RRDY=7, E=8.
- Access timing:
  - Each access drives chipselect=1, begintransfer=1 and the strobe low for exactly one cycle (cycle N).
  - Reads sample av_readdata at the clock edge ending cycle N+1.
  - All av_* outputs are idle in every other cycle.
  - Minimum two cycles per access; no back-to-back strobes.
- TX holding register (1 entry):
  - tx_ready = ~tx_full once INIT is done; tx_ready=0 during INIT.
  - tx_valid & tx_ready loads tx_data and sets tx_full.
  - tx_full clears in the WR_TX strobe cycle.
- RX output register (1 entry):
  - rx_valid set with rx_data at RD_RX sample; cleared on rx_valid & rx_ready.
  - While rx_valid=1, RRDY is ignored; the byte stays in the UART, so ROE may result.
- FSM:
  - INIT_DIV: write INIT_DIVISOR to addr 4. Skipped if INIT_DIVISOR==0.
  - INIT_CTL: write INIT_CONTROL to addr 3.
  - IDLE: wait POLL_GAP cycles, then go to POLL.
  - POLL: read addr 2.
  - WAIT_ST: sample status, then DECIDE.
  - DECIDE, priority order:
    1. E=1: go to CLR_ST.
    2. Both wants: RX want = RRDY & ~rx_valid; TX want = TRDY & tx_full. If both, grant the side opposite last_grant.
    3. Single want: grant it.
    4. Neither: go to IDLE.
  - CLR_ST: write 0 to addr 2, set err_sticky if PE|FE|ROE, then go to POLL.
  - WR_TX: write {8'h00, tx_byte} to addr 1; last_grant=TX; then POLL.
  - RD_RX: read addr 0.
  - WAIT_RX: capture readdata[7:0] into rx_data; last_grant=RX; then POLL.
  - After any transfer, POLL immediately with no gap.
- Error flag: err_clr has priority over a simultaneous set, so same-cycle set+clr clears err_sticky.
- Simultaneous tx accept and WR_TX strobe: the load waits a cycle, because tx_ready is low while tx_full=1.
- Reset mid-access returns everything to reset values and re-runs INIT; a buffered TX byte is discarded.

Optional Feature:
- Macro: UART_CTRL_IRQ_EN.
- Defined: IDLE leaves for POLL only when av_irq=1, or tx_full=1, or rx_valid has just cleared; POLL_GAP still applies as the minimum gap.
- Undefined: av_irq is ignored and polling is periodic every POLL_GAP idle cycles.

Decomposition:
- Package uart_ctrl_pkg holds:
  - register address constants (ADDR_RXDATA..ADDR_DIVISOR);
  - status bit indices (ST_PE, ST_FE, ST_ROE, ST_TRDY, ST_RRDY, ST_E);
  - state enum typedef;
  - grant enum {GRANT_RX, GRANT_TX}.
- One natural sub-module: uart_ctrl_arb, the combinational RX/TX round-robin decision plus last_grant register.

Test Plan:
- Init with INIT_DIVISOR=434, INIT_CONTROL=0 -> write addr4 data 16'h01B2, then write addr3 data 16'h0000, then first read addr2; tx_ready rises after INIT_CTL.
- tx 8'hA5, model status 16'h0040 -> write addr1 data 16'h00A5 within 3 cycles of WAIT_ST; tx_ready returns high.
- Status 16'h0080, rxdata 16'h003C, rx_ready=0 for 20 cycles -> rx_valid=1, rx_data=8'h3C held; no further addr0 read until rx_ready pulse.
- Status 16'h00C0 continuously with a TX byte always pending and rx_ready=1 -> grants alternate RX, TX, RX, TX (first grant RX).
- Status 16'h0108 (E+ROE) -> write addr2 data 0, err_sticky=1; err_clr pulse -> err_sticky=0.
- Reset asserted during RD_RX strobe -> av_read_n=1 and av_chipselect=0 immediately (asynchronous); after release, INIT sequence repeats.
